// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch front end: ROM window constants, the
// fetch FSM encoding and the ROM-window range check (also used by load/store).
package instr_fetch_pkg;

    localparam logic [31:0] ROM_BASE_DEF = 32'hBFC0_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // True when a byte address is misaligned or lies outside the populated ROM words.
    function automatic logic pc_out_of_window(input logic [31:0] pc,
                                              input logic [31:0] base,
                                              input logic [31:0] depth);
        logic [31:0] offset;
        offset = pc - base;
        return (pc[1:0] != 2'b00) || (pc < base) || ((offset >> 2) >= depth);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: PC register, ROM address generation, IF/ID
// output register with valid/ready, redirect handling and bad-PC fault halt.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          ROM_AW    = 5,
    parameter int          ROM_DEPTH = 24,
    parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fetch_fault,
    output logic [31:0]       fault_pc,
    output logic [31:0]       fetch_count
);

    fetch_state_t state, state_next;
    logic [31:0]  pc;
    logic         fetch_slot;
    logic         pc_bad;

    assign rom_addr   = pc[ROM_AW+1:2];
    assign fetch_slot = (state == RUN) && (!if_valid || id_ready);
    assign pc_bad     = pc_out_of_window(pc, ROM_BASE, 32'(ROM_DEPTH));

    // Next FSM state: a redirect always restarts fetching; a bad PC in a fetch slot halts.
    always_comb begin
        state_next = state;
        if (redirect_valid)
            state_next = RUN;
        else if (fetch_slot && pc_bad)
            state_next = HALT;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // PC, IF/ID register and fault capture; redirect beats fault beats fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 32'h0;
            if_pc       <= 32'h0;
            fetch_fault <= 1'b0;
            fault_pc    <= 32'h0;
        end else if (redirect_valid) begin
            // Held instruction is dropped; target is fetched on the following edge.
            pc          <= redirect_pc;
            if_valid    <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (fetch_slot) begin
            if (pc_bad) begin
                // ROM data is undefined here, so it is never latched.
                fetch_fault <= 1'b1;
                fault_pc    <= pc;
                if_valid    <= 1'b0;
            end else begin
                if_instr <= rom_instr;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc + 32'd4;
            end
        end
    end

    // Accepted-instruction counter; counts the handshake even on a redirect edge.
    always_ff @(posedge clk) begin
        if (reset)
            fetch_count <= 32'h0;
        else if (if_valid && id_ready)
            fetch_count <= fetch_count + 32'd1;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected accepted
// instructions, a negedge monitor pops one on every if_valid & id_ready.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rom_addr;
    logic [31:0] rom_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_instr(rom_instr),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    // Boot ROM contents beside the block; unpopulated words return a marker value.
    function automatic logic [31:0] rom_word(input logic [4:0] a);
        case (a)
            5'd0:    return 32'h3c08dead;
            5'd1:    return 32'h3508beef;
            5'd2:    return 32'hac08fff0;
            5'd3:    return 32'h3c018000;
            5'd16:   return 32'h8c230000;
            5'd23:   return 32'h00001fcd;
            default: return (a < 5'd24) ? {24'h1000_00, 3'b0, a} : {24'hBAD000, 3'b0, a};
        endcase
    endfunction
    assign rom_instr = rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'h0);
        chk({tag, "_if_pc"}, if_pc, 32'h0);
        chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
        chk({tag, "_fault_pc"}, fault_pc, 32'h0);
        chk({tag, "_count"}, fetch_count, 32'h0);
        chk({tag, "_rom_addr"}, {27'b0, rom_addr}, 32'd0);
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0 && if_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", if_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_instr", if_instr, e.instr);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        chk_reset_state("reset");

        // Sequential fetch from the reset PC.
        push(32'hBFC00000, 32'h3c08dead);
        push(32'hBFC00004, 32'h3508beef);
        push(32'hBFC00008, 32'hac08fff0);
        reset = 1'b0;
        tick();
        chk("first_valid", {31'b0, if_valid}, 32'd1);
        tick();
        tick();
        id_ready = 1'b0;
        chk("pre_stall_count", fetch_count, 32'd2);

        // Stall on BFC00008 for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", if_pc, 32'hBFC00008);
            chk("stall_instr", if_instr, 32'hac08fff0);
            chk("stall_count", fetch_count, 32'd2);
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("release_pc", if_pc, 32'hBFC0000C);
        chk("release_instr", if_instr, 32'h3c018000);
        chk("release_count", fetch_count, 32'd3);

        // Redirect while stalled drops BFC0000C without counting it.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00040;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, if_valid}, 32'd0);
        chk("redir_count", fetch_count, 32'd3);
        for (int w = 16; w < 24; w++)
            push(32'hBFC00000 + 32'(w * 4), rom_word(5'(w)));
        id_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();

        // Ran off the end of the populated window.
        chk("win_fault", {31'b0, fetch_fault}, 32'd1);
        chk("win_fault_pc", fault_pc, 32'hBFC00060);
        chk("win_valid", {31'b0, if_valid}, 32'd0);
        chk("win_count", fetch_count, 32'd11);
        tick();
        tick();
        chk("halt_hold_fault", {31'b0, fetch_fault}, 32'd1);
        chk("halt_hold_count", fetch_count, 32'd11);

        // Recover by redirecting to the ROM base.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00000;
        tick();
        redirect_valid = 1'b0;
        chk("recover_fault", {31'b0, fetch_fault}, 32'd0);
        push(32'hBFC00000, 32'h3c08dead);
        tick();

        // Misaligned redirect target; the redirect edge still counts the accepted word.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00006;
        tick();
        redirect_valid = 1'b0;
        chk("mis_redir_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_fault_pc", fault_pc, 32'hBFC00006);
        chk("mis_count", fetch_count, 32'd12);

        // Below-window target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000000;
        tick();
        redirect_valid = 1'b0;
        chk("low_cleared", {31'b0, fetch_fault}, 32'd0);
        tick();
        chk("low_fault", {31'b0, fetch_fault}, 32'd1);
        chk("low_fault_pc", fault_pc, 32'h00000000);

        // Reset during HALT.
        reset = 1'b1;
        tick();
        chk_reset_state("rst_halt");
        reset    = 1'b0;
        id_ready = 1'b0;

        // Reset during a stall.
        tick();
        chk("stall2_valid", {31'b0, if_valid}, 32'd1);
        chk("stall2_pc", if_pc, 32'hBFC00000);
        tick();
        chk("stall2_hold_pc", if_pc, 32'hBFC00000);
        reset = 1'b1;
        tick();
        chk_reset_state("rst_stall");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
